imem_boot_loader: RTL

- Upstream stage of the single-cycle RISC-V core: loads the program image into instruction memory from a byte stream (UART receiver or testbench) before the core runs.
- Byte-wide valid/ready input; assembles little-endian 32-bit words and issues one instruction-memory write per word.
- Holds the core in reset until the full image is written, then releases it.
- Reports done/error status to top level.

---
 rtl/imem_boot_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: builds 32-bit little-endian words, writes them into
// instruction memory and holds the core in reset until the image is complete.
// Optional trailing XOR checksum byte is enabled with `define BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHK    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       CAPACITY = 32'd1 << ADDR_W;

    state_t              r_state;
    logic [15:0]         r_len;
    logic [15:0]         r_word_cnt;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_in_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_core_rst_n;
    logic                r_done;
    logic                r_error;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]          r_chk;
`endif

    logic                w_accept;
    logic [15:0]         w_len_full;
    logic                w_last_word;

    assign w_accept    = in_valid & r_in_ready;
    assign w_len_full  = {in_data, r_len[7:0]};
    assign w_last_word = (r_word_cnt == (r_len - 16'd1));

    // Loader FSM with all outputs registered; restart outranks any byte accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_LEN_LO;
            r_len        <= 16'd0;
            r_word_cnt   <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'd0;
            r_wr_addr    <= BASE;
            r_in_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= BASE;
            r_wdata      <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_chk        <= 8'd0;
`endif
        end else if (restart) begin
            r_state      <= S_LEN_LO;
            r_len        <= 16'd0;
            r_word_cnt   <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'd0;
            r_wr_addr    <= BASE;
            r_in_ready   <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= BASE;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_chk        <= 8'd0;
`endif
        end else begin
            r_we         <= 1'b0;
            r_done       <= (r_state == S_DONE);
            r_core_rst_n <= (r_state == S_DONE);
            case (r_state)
                S_LEN_LO: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_len[15:8] <= in_data;
                        if (w_len_full == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
`endif
                        end else if ({16'd0, w_len_full} > CAPACITY) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
`ifdef BOOT_CHECKSUM_EN
                        r_chk <= r_chk ^ in_data;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            // Fourth byte completes the word; strobe goes out next cycle.
                            r_we       <= 1'b1;
                            r_wdata    <= {in_data, r_shift};
                            r_addr     <= r_wr_addr;
                            r_wr_addr  <= r_wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                            r_word_cnt <= r_word_cnt + 16'd1;
                            r_byte_cnt <= 2'd0;
                            if (w_last_word) begin
`ifdef BOOT_CHECKSUM_EN
                                r_state    <= S_CHK;
`else
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
`endif
                            end
                        end else begin
                            r_shift    <= {in_data, r_shift[23:8]};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CHK: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_chk) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_in_ready <= 1'b0;
                end
                S_ERR: begin
                    r_in_ready <= 1'b0;
                    r_error    <= 1'b1;
                end
                default: begin
                    r_state    <= S_ERR;
                    r_in_ready <= 1'b0;
                    r_error    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_reset_n = r_core_rst_n;
    assign done         = r_done;
    assign error        = r_error;

endmodule
